// File: rtl/car_sprite_arbiter_if.sv
// Request/ROM/response bundle for the car sprite arbiter.
// The DUT uses the slave modport; the requesters, ROM and sink use the master modport.
interface car_sprite_arbiter_if;
  logic        req0;
  logic        req1;
  logic [5:0]  x0;
  logic [5:0]  x1;
  logic [7:0]  y0;
  logic [7:0]  y1;
  logic [2:0]  lives0;
  logic [2:0]  lives1;
  logic        ack0;
  logic        ack1;
  logic [15:0] rom_addr;
  logic [23:0] rom_pixel;
  logic        rsp_valid;
  logic        rsp_id;
  logic [23:0] rsp_pixel;
  logic        rsp_transparent;

  modport master (
    output req0, req1, x0, x1, y0, y1, lives0, lives1, rom_pixel,
    input  ack0, ack1, rom_addr, rsp_valid, rsp_id, rsp_pixel, rsp_transparent
  );

  modport slave (
    input  req0, req1, x0, x1, y0, y1, lives0, lives1, rom_pixel,
    output ack0, ack1, rom_addr, rsp_valid, rsp_id, rsp_pixel, rsp_transparent
  );
endinterface

// File: rtl/car_sprite_arbiter.sv
// Round-robin arbiter sharing one car sprite ROM between two pixel requesters.
// Grant -> registered ROM address -> ROM latency -> registered response (3 cycles).
module car_sprite_arbiter #(
  parameter int unsigned SPRITE_W    = 64,
  parameter int unsigned SPRITE_H    = 130,
  parameter int unsigned FRAME_WORDS = 8320
) (
  input logic                 i_clk,
  input logic                 i_rst,
  car_sprite_arbiter_if.slave io_bus
);

  localparam logic [23:0] ColourKey = 24'hFFFFFF;

  logic        r_ptr;
  logic [15:0] r_rom_addr;
  logic        r_s1_vld;
  logic        r_s1_id;
  logic        r_s1_oor;
  logic        r_s2_vld;
  logic        r_s2_id;
  logic        r_s2_oor;
  logic        r_rsp_vld;
  logic        r_rsp_id;
  logic [23:0] r_rsp_pixel;
  logic        r_rsp_transp;

  logic        w_ack0;
  logic        w_ack1;
  logic        w_grant;
  logic        w_gnt_id;
  logic [5:0]  w_x;
  logic [7:0]  w_y;
  logic [2:0]  w_lives;
  logic [2:0]  w_lives_c;
  logic [2:0]  w_frame;
  logic        w_oor;
  logic [15:0] w_addr;
  logic [23:0] w_pixel;

  // Favoured requester wins a tie; acks are forced low while reset is high.
  always_comb begin
    w_ack0 = 1'b0;
    w_ack1 = 1'b0;
    if (!i_rst) begin
      if (io_bus.req0 && (!io_bus.req1 || !r_ptr)) begin
        w_ack0 = 1'b1;
      end else if (io_bus.req1) begin
        w_ack1 = 1'b1;
      end
    end
  end

  assign w_grant  = w_ack0 | w_ack1;
  assign w_gnt_id = w_ack1;

  always_comb begin
    w_x     = w_gnt_id ? io_bus.x1     : io_bus.x0;
    w_y     = w_gnt_id ? io_bus.y1     : io_bus.y0;
    w_lives = w_gnt_id ? io_bus.lives1 : io_bus.lives0;
  end

  always_comb begin
    w_lives_c = w_lives;
    if (w_lives == 3'd0) begin
      w_lives_c = 3'd1;
    end else if (w_lives > 3'd5) begin
      w_lives_c = 3'd5;
    end
  end

  // Frame 0 holds the five-lives sprite; the largest address (41599) fits 16 bits.
  assign w_frame = 3'd5 - w_lives_c;
  assign w_oor   = 32'(w_y) >= SPRITE_H;
  assign w_addr  = 16'(w_frame) * 16'(FRAME_WORDS) + 16'(w_y) * 16'(SPRITE_W) + 16'(w_x);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr      <= 1'b0;
      r_rom_addr <= '0;
    end else if (w_grant) begin
      r_ptr      <= ~w_gnt_id;
      r_rom_addr <= w_oor ? 16'd0 : w_addr;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_vld <= 1'b0;
      r_s1_id  <= 1'b0;
      r_s1_oor <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s2_id  <= 1'b0;
      r_s2_oor <= 1'b0;
    end else begin
      r_s1_vld <= w_grant;
      r_s1_id  <= w_gnt_id;
      r_s1_oor <= w_oor;
      r_s2_vld <= r_s1_vld;
      r_s2_id  <= r_s1_id;
      r_s2_oor <= r_s1_oor;
    end
  end

  // Out-of-range requests ignore the ROM and come back as the transparent key.
  assign w_pixel = r_s2_oor ? ColourKey : io_bus.rom_pixel;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_vld    <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_pixel  <= '0;
      r_rsp_transp <= 1'b0;
    end else begin
      r_rsp_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_rsp_id     <= r_s2_id;
        r_rsp_pixel  <= w_pixel;
        r_rsp_transp <= (w_pixel == ColourKey);
      end
    end
  end

  assign io_bus.ack0            = w_ack0;
  assign io_bus.ack1            = w_ack1;
  assign io_bus.rom_addr        = r_rom_addr;
  assign io_bus.rsp_valid       = r_rsp_vld;
  assign io_bus.rsp_id          = r_rsp_id;
  assign io_bus.rsp_pixel       = r_rsp_pixel;
  assign io_bus.rsp_transparent = r_rsp_transp;

endmodule

// File: tb/tb_car_sprite_arbiter.sv
// Directed bench for car_sprite_arbiter with a one-cycle-latency ROM model.
module tb_car_sprite_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  car_sprite_arbiter_if bus ();

  car_sprite_arbiter #(
    .SPRITE_W   (64),
    .SPRITE_H   (130),
    .FRAME_WORDS(8320)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  // ROM contents: address 100 holds the colour key, everything else tags its address.
  always @(posedge clk) begin
    if (bus.rom_addr == 16'd100) bus.rom_pixel <= 24'hFFFFFF;
    else                         bus.rom_pixel <= {8'h5A, bus.rom_addr};
  end

  logic [15:0] b_addr [4] = '{16'd0, 16'd16773, 16'd0, 16'd16773};
  logic [23:0] b_pix  [4] = '{24'h5A0000, 24'h5A4185, 24'h5A0000, 24'h5A4185};

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, " ack0"}, bus.ack0, 1'b0);
    chk1({tag, " ack1"}, bus.ack1, 1'b0);
    chk16({tag, " rom_addr"}, bus.rom_addr, 16'd0);
    chk1({tag, " rsp_valid"}, bus.rsp_valid, 1'b0);
    chk1({tag, " rsp_id"}, bus.rsp_id, 1'b0);
    chk24({tag, " rsp_pixel"}, bus.rsp_pixel, 24'd0);
    chk1({tag, " rsp_transparent"}, bus.rsp_transparent, 1'b0);
  endtask

  // One isolated request, followed through address, response and hold.
  task automatic single(input bit id, input logic [2:0] lv, input logic [5:0] x,
                        input logic [7:0] y, input logic [15:0] eaddr,
                        input logic [23:0] epix, input logic etr, input string tag);
    if (!id) begin
      bus.lives0 = lv; bus.x0 = x; bus.y0 = y; bus.req0 = 1'b1;
    end else begin
      bus.lives1 = lv; bus.x1 = x; bus.y1 = y; bus.req1 = 1'b1;
    end
    #1;
    chk1({tag, " ack0"}, bus.ack0, !id);
    chk1({tag, " ack1"}, bus.ack1, id);
    tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk16({tag, " rom_addr"}, bus.rom_addr, eaddr);
    tick();
    chk1({tag, " early valid"}, bus.rsp_valid, 1'b0);
    tick();
    chk1({tag, " rsp_valid"}, bus.rsp_valid, 1'b1);
    chk1({tag, " rsp_id"}, bus.rsp_id, id);
    chk24({tag, " rsp_pixel"}, bus.rsp_pixel, epix);
    chk1({tag, " rsp_transparent"}, bus.rsp_transparent, etr);
    tick();
    chk1({tag, " valid drop"}, bus.rsp_valid, 1'b0);
    chk24({tag, " pixel hold"}, bus.rsp_pixel, epix);
    chk1({tag, " transp hold"}, bus.rsp_transparent, etr);
  endtask

  initial begin
    bus.req0 = 1'b1;
    bus.req1 = 1'b0;
    bus.x0 = 6'd0;  bus.y0 = 8'd0;  bus.lives0 = 3'd5;
    bus.x1 = 6'd5;  bus.y1 = 8'd2;  bus.lives1 = 3'd3;
    rst = 1'b1;
    repeat (2) tick();
    chk_all_zero("reset");

    // Both requesters held for four grants starting in the reset-release cycle.
    rst = 1'b0;
    bus.req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      #1;
      chk1("burst ack0", bus.ack0, (i < 4) && (i % 2 == 0));
      chk1("burst ack1", bus.ack1, (i < 4) && (i % 2 == 1));
      if (i >= 1) chk16("burst rom_addr", bus.rom_addr, b_addr[(i - 1 > 3) ? 3 : i - 1]);
      chk1("burst rsp_valid", bus.rsp_valid, (i >= 3) && (i <= 6));
      if (i >= 3 && i <= 6) begin
        chk1("burst rsp_id", bus.rsp_id, ((i - 3) % 2) == 1);
        chk24("burst rsp_pixel", bus.rsp_pixel, b_pix[i - 3]);
      end
      tick();
    end

    single(1'b1, 3'd1, 6'd63, 8'd129, 16'd41599, 24'h5AA27F, 1'b0, "max addr");
    single(1'b1, 3'd3, 6'd5,  8'd2,   16'd16773, 24'h5A4185, 1'b0, "lives3");
    single(1'b0, 3'd0, 6'd0,  8'd0,   16'd33280, 24'h5A8200, 1'b0, "lives0 clamp");
    single(1'b0, 3'd5, 6'd3,  8'd130, 16'd0,     24'hFFFFFF, 1'b1, "y out of range");
    single(1'b0, 3'd7, 6'd0,  8'd0,   16'd0,     24'h5A0000, 1'b0, "lives7 clamp");
    single(1'b0, 3'd5, 6'd36, 8'd1,   16'd100,   24'hFFFFFF, 1'b1, "rom key");

    // Last grant went to requester 0, so requester 1 is favoured next.
    bus.lives0 = 3'd5; bus.x0 = 6'd0; bus.y0 = 8'd0;
    bus.lives1 = 3'd3; bus.x1 = 6'd5; bus.y1 = 8'd2;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    #1;
    chk1("pre-reset ack1", bus.ack1, 1'b1);
    tick();
    chk1("pre-reset ack0", bus.ack0, 1'b1);
    tick();
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    #1;
    chk_all_zero("mid reset");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1("flushed rsp_valid", bus.rsp_valid, 1'b0);
      tick();
    end
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    #1;
    chk1("post-reset ack0", bus.ack0, 1'b1);
    chk1("post-reset ack1", bus.ack1, 1'b0);
    tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/car_sprite_arbiter.md
CAR_SPRITE_ARBITER -- requirements
Module: car_sprite_arbiter

Interface
REQ-001 Parameter SPRITE_W, default 64, SHALL be the sprite width in pixels (words per row).
REQ-002 Parameter SPRITE_H, default 130, SHALL be the sprite height in rows.
REQ-003 Parameter FRAME_WORDS, default 8320, SHALL be the words per lives frame (SPRITE_W*SPRITE_H).
REQ-004 Clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Reset  in  1  SHALL be the reset, asynchronous and active-high.
REQ-006 req0, req1  in  1 each  SHALL be the pixel-read requests from requester 0 and requester 1; each is held until acked.
REQ-007 x0, x1  in  6 each  SHALL be the sprite column of each request.
REQ-008 y0, y1  in  8 each  SHALL be the sprite row of each request.
REQ-009 lives0, lives1  in  3 each  SHALL be the lives count that selects the frame.
REQ-010 ack0, ack1  out  1 each  SHALL be combinational one-cycle grant pulses.
REQ-011 rom_addr  out  16  SHALL be the registered read address to the car sprite ROM.
REQ-012 rom_pixel  in  24  SHALL be the decoded ROM RGB output, valid one cycle after rom_addr is presented.
REQ-013 rsp_valid  out  1  SHALL flag a response.
REQ-014 rsp_id  out  1  SHALL be the requester index of the response.
REQ-015 rsp_pixel  out  24  SHALL be the RGB of the response.
REQ-016 rsp_transparent  out  1  SHALL be 1 when rsp_pixel is the colour key 24'hFFFFFF.

Function
REQ-017 At most one ack SHALL be asserted per cycle, and only for an asserted req.
REQ-018 Arbitration SHALL be round-robin: a priority pointer (reset 0) picks the favoured requester; after a grant the pointer SHALL move to the other requester; with one requester active, that requester SHALL be granted every cycle.
REQ-019 A requester SHALL receive ack in the cycle its req is sampled and granted; it may change x/y/lives or drop req on the next cycle.
REQ-020 Lives SHALL be clamped: L = 1 if lives = 0, L = 5 if lives > 5, otherwise L = lives.
REQ-021 Address SHALL be (5-L)*FRAME_WORDS + y*SPRITE_W + x, computed in at least 16 bits with no truncation; the maximum is 41599.
REQ-022 A request with y >= SPRITE_H SHALL be out-of-range: it is granted normally, rom_addr SHALL be driven 0, and its response SHALL be rsp_pixel = 24'hFFFFFF with rsp_transparent = 1.
REQ-023 Pipeline: grant in cycle N loads rom_addr at the end of N; the ROM samples at the end of N+1; rom_pixel is valid in N+2; response registers load at the end of N+2; rsp_valid is high in cycle N+3.
REQ-024 Valid, id and out-of-range flags SHALL travel with each stage; the pipeline SHALL accept one grant per cycle with no bubbles (throughput 1 pixel/cycle).
REQ-025 In idle cycles (no grant), rom_addr SHALL hold its last value and no response SHALL be produced 3 cycles later.
REQ-026 rsp_* outputs other than rsp_valid SHALL hold their previous values while rsp_valid = 0.
REQ-027 req asserted in the same cycle Reset deasserts SHALL be eligible for grant in that cycle.

Reset
REQ-028 On Reset, the block SHALL clear immediately: pointer 0, all pipeline valids 0, rom_addr 0, rsp_valid 0, rsp_id 0, rsp_pixel 0, rsp_transparent 0.
REQ-029 ack0 and ack1 SHALL be 0 while Reset is high.
REQ-030 In-flight requests SHALL be discarded on Reset with no response.

Verification
REQ-031 req0 only, lives0=5, x0=0, y0=0 -> ack0 in cycle N; rom_addr=0 in N+1; rsp_valid=1, rsp_id=0 in N+3.
REQ-032 req1 only, lives1=1, x1=63, y1=129 -> rom_addr=41599; req1 with lives1=3, x1=5, y1=2 -> rom_addr=16773.
REQ-033 Clamp checks: lives=0, x=0, y=0 -> rom_addr=33280; lives=7, x=0, y=0 -> rom_addr=0.
REQ-034 req0 and req1 both held for 4 cycles from reset -> ack sequence 0,1,0,1; four rsp_valid in consecutive cycles with ids 0,1,0,1.
REQ-035 y0=130 -> rom_addr=0; 3 cycles after ack, rsp_pixel=FFFFFF and rsp_transparent=1; a ROM pixel of FFFFFF at an in-range address also gives rsp_transparent=1.
REQ-036 Reset pulsed 1 cycle after two grants -> no rsp_valid afterwards, all outputs 0, pointer 0 (next simultaneous request grants req0).
